// File: rtl/ysyx_24100006_memu_pkg.sv
// Shared types for the memory-access stage: FSM states, access-size codes,
// AXI response codes and the pass-through writeback bundle.
package ysyx_24100006_memu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } memu_state_e;

   typedef enum logic [2:0] {
      MT_B  = 3'b000,
      MT_H  = 3'b001,
      MT_W  = 3'b010,
      MT_BU = 3'b100,
      MT_HU = 3'b101
   } mem_type_e;

   typedef logic [1:0] axi_resp_t;
   localparam axi_resp_t RESP_OKAY = 2'b00;

   // Fields that travel unchanged from EX_MEM to MEM_WB
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] sext_imm;
      logic [31:0] rs1_data;
      logic [31:0] rdata_csr;
      logic [3:0]  gpr_waddr;
      logic [11:0] csr_waddr;
      logic [2:0]  gpr_wrd;
      logic [1:0]  csr_wrd;
      logic [7:0]  irq_no;
      logic        irq;
      logic        gpr_write;
      logic        csr_write;
      logic        is_break;
   } wb_bundle_t;

endpackage

// File: rtl/ysyx_24100006_memu_if.sv
// AXI4-Lite bus between the memory stage (master) and a data slave.
interface ysyx_24100006_memu_if
   import ysyx_24100006_memu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   axi_resp_t             rresp;
   logic                  rvalid;
   logic                  rready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   axi_resp_t             bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_24100006_mem_align.sv
// Store lane replication / byte strobes and load lane extraction / extension.
// Low address bits below the access size are ignored; the bus address itself
// is never touched here.
module ysyx_24100006_mem_align
   import ysyx_24100006_memu_pkg::*;
(
   input  logic [2:0]  mem_type_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] bus_rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] load_data_o
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed lane and format both directions for the access size
   always_comb begin
      lane_b      = 8'(bus_rdata_i >> {addr_lo_i, 3'b000});
      lane_h      = 16'(bus_rdata_i >> {addr_lo_i[1], 4'b0000});
      wdata_o     = store_data_i;
      wstrb_o     = 4'b1111;
      load_data_o = bus_rdata_i;
      case (mem_type_i)
         MT_B: begin
            wdata_o     = {4{store_data_i[7:0]}};
            wstrb_o     = 4'b0001 << addr_lo_i;
            load_data_o = {{24{lane_b[7]}}, lane_b};
         end
         MT_BU: begin
            wdata_o     = {4{store_data_i[7:0]}};
            wstrb_o     = 4'b0001 << addr_lo_i;
            load_data_o = {24'd0, lane_b};
         end
         MT_H: begin
            wdata_o     = {2{store_data_i[15:0]}};
            wstrb_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
            load_data_o = {{16{lane_h[15]}}, lane_h};
         end
         MT_HU: begin
            wdata_o     = {2{store_data_i[15:0]}};
            wstrb_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
            load_data_o = {16'd0, lane_h};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/ysyx_24100006_memu.sv
// Memory-access stage: one instruction in flight, loads/stores issued as an
// AXI4-Lite master, full writeback bundle handed to MEM_WB over valid/ready.
module ysyx_24100006_memu
   import ysyx_24100006_memu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [31:0] pc_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] sext_imm_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rdata_csr_i,
   input  logic [31:0] rs2_data_i,
   input  logic        Mem_Read_i,
   input  logic        Mem_Write_i,
   input  logic [2:0]  Mem_Type_i,
   input  logic [3:0]  Gpr_Write_Addr_i,
   input  logic [11:0] Csr_Write_Addr_i,
   input  logic [2:0]  Gpr_Write_RD_i,
   input  logic [1:0]  Csr_Write_RD_i,
   input  logic [7:0]  irq_no_i,
   input  logic        irq_i,
   input  logic        Gpr_Write_i,
   input  logic        Csr_Write_i,
   input  logic        is_break_i,
   output logic [31:0] pc_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] sext_imm_o,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rdata_csr_o,
   output logic [31:0] Mem_rdata_o,
   output logic        mem_err_o,
   output logic [3:0]  Gpr_Write_Addr_o,
   output logic [11:0] Csr_Write_Addr_o,
   output logic [2:0]  Gpr_Write_RD_o,
   output logic [1:0]  Csr_Write_RD_o,
   output logic [7:0]  irq_no_o,
   output logic        irq_o,
   output logic        Gpr_Write_o,
   output logic        Csr_Write_o,
   output logic        is_break_o,
   ysyx_24100006_memu_if.master axi
);
   memu_state_e state_q;
   wb_bundle_t  bundle_q;
   logic [31:0] rs2_q;
   logic [2:0]  mtype_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, out_valid_q;
   logic        aw_done_q, w_done_q, aw_done_d, w_done_d;
   logic        accept, aw_fire, w_fire;
   logic [31:0] load_data;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign aw_fire   = awvalid_q && axi.awready;
   assign w_fire    = wvalid_q && axi.wready;
   assign aw_done_d = aw_done_q || aw_fire;
   assign w_done_d  = w_done_q || w_fire;

   ysyx_24100006_mem_align u_align (
      .mem_type_i   (mtype_q),
      .addr_lo_i    (bundle_q.alu_result[1:0]),
      .store_data_i (rs2_q),
      .bus_rdata_i  (axi.rdata),
      .wdata_o      (axi.wdata),
      .wstrb_o      (axi.wstrb),
      .load_data_o  (load_data)
   );

   // Control FSM with registered bus valids and writeback fields; an accept
   // (from IDLE or from DONE on the draining cycle) overrides the case result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bundle_q    <= '0;
         rs2_q       <= '0;
         mtype_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         out_valid_q <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            ST_AR: if (axi.arready) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               state_q   <= ST_R;
            end
            ST_R: if (axi.rvalid) begin
               rready_q    <= 1'b0;
               err_q       <= (axi.rresp != RESP_OKAY);
               rdata_q     <= (axi.rresp != RESP_OKAY) ? 32'd0 : load_data;
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_AW_W: begin
               if (aw_fire) awvalid_q <= 1'b0;
               if (w_fire)  wvalid_q  <= 1'b0;
               if (aw_done_d && w_done_d) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= ST_B;
               end else begin
                  aw_done_q <= aw_done_d;
                  w_done_q  <= w_done_d;
               end
            end
            ST_B: if (axi.bvalid) begin
               bready_q    <= 1'b0;
               err_q       <= (axi.bresp != RESP_OKAY);
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: ;
         endcase

         if (accept) begin
            bundle_q <= '{pc: pc_i, alu_result: alu_result_i, sext_imm: sext_imm_i,
                          rs1_data: rs1_data_i, rdata_csr: rdata_csr_i,
                          gpr_waddr: Gpr_Write_Addr_i, csr_waddr: Csr_Write_Addr_i,
                          gpr_wrd: Gpr_Write_RD_i, csr_wrd: Csr_Write_RD_i,
                          irq_no: irq_no_i, irq: irq_i, gpr_write: Gpr_Write_i,
                          csr_write: Csr_Write_i, is_break: is_break_i};
            rs2_q   <= rs2_data_i;
            mtype_q <= Mem_Type_i;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            if (Mem_Read_i) begin
               arvalid_q   <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= ST_AR;
            end else if (Mem_Write_i) begin
               awvalid_q   <= 1'b1;
               wvalid_q    <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= ST_AW_W;
            end else begin
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
         end
      end
   end

   assign axi.araddr  = bundle_q.alu_result[ADDR_WIDTH-1:0];
   assign axi.awaddr  = bundle_q.alu_result[ADDR_WIDTH-1:0];
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;

   assign out_valid        = out_valid_q;
   assign pc_o             = bundle_q.pc;
   assign alu_result_o     = bundle_q.alu_result;
   assign sext_imm_o       = bundle_q.sext_imm;
   assign rs1_data_o       = bundle_q.rs1_data;
   assign rdata_csr_o      = bundle_q.rdata_csr;
   assign Mem_rdata_o      = rdata_q;
   assign mem_err_o        = err_q;
   assign Gpr_Write_Addr_o = bundle_q.gpr_waddr;
   assign Csr_Write_Addr_o = bundle_q.csr_waddr;
   assign Gpr_Write_RD_o   = bundle_q.gpr_wrd;
   assign Csr_Write_RD_o   = bundle_q.csr_wrd;
   assign irq_no_o         = bundle_q.irq_no;
   assign irq_o            = bundle_q.irq;
   assign Gpr_Write_o      = bundle_q.gpr_write;
   assign Csr_Write_o      = bundle_q.csr_write;
   assign is_break_o       = bundle_q.is_break;
endmodule

// File: doc/ysyx_24100006_memu.md
Name: ysyx_24100006_memu

Overview:
Memory-access stage between EX_MEM and MEM_WB. It accepts one instruction at a time over a valid/ready handshake and performs loads and stores as an AXI4-Lite master. Load data is aligned and extended before it goes downstream. The block presents the complete writeback bundle to MEM_WB over valid/ready; instructions that do not access memory pass through after one cycle.

Parameters:
ADDR_WIDTH, 32, byte-address width of the AXI4-Lite master (data fixed at 32 bits).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid / in_ready  in/out  1  handshake from EX_MEM
out_valid / out_ready  out/in  1  handshake to MEM_WB
pc_i / pc_o  in/out  32  instruction PC, passed through
alu_result_i / alu_result_o  in/out  32  effective address or ALU result, passed through
sext_imm_i, rs1_data_i, rdata_csr_i (and _o)  in/out  32  passed through
rs2_data_i  in  32  store data
Mem_Read_i, Mem_Write_i  in  1  load / store request (never both)
Mem_Type_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
Mem_rdata_o  out  32  aligned, extended load data; 0 for non-loads
mem_err_o  out  1  bus returned a non-OKAY response for this instruction
Gpr_Write_Addr_i/_o  in/out  4;  Csr_Write_Addr_i/_o  12;  Gpr_Write_RD_i/_o  3;  Csr_Write_RD_i/_o  2;  irq_no_i/_o  8  passed through
irq_i/_o, Gpr_Write_i/_o, Csr_Write_i/_o, is_break_i/_o  in/out  1  passed through
araddr, arvalid, arready, rdata(32), rresp(2), rvalid, rready  AXI4-Lite read channels
awaddr, awvalid, awready, wdata(32), wstrb(4), wvalid, wready, bresp(2), bvalid, bready  AXI4-Lite write channels

Behaviour:
- States: IDLE, AR, R, AW_W, B, DONE. Reset puts the FSM in IDLE and clears all valids (arvalid, awvalid, wvalid, out_valid), rready, bready, all output registers and mem_err_o to 0. A reset mid-transaction drops the transaction; bus slaves reset with the core.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Input fields are latched into internal registers on in_valid && in_ready.
- Transition on accept:
  - Mem_Read -> AR
  - Mem_Write -> AW_W
  - otherwise -> DONE. Non-memory latency is 1 cycle from accept to out_valid.
- AR: arvalid=1, araddr=latched address. On arready -> R.
- R: rready=1. On rvalid, capture the extracted data and set err = (rresp!=0), then -> DONE. Load latency is at least 3 cycles.
- AW_W: awvalid and wvalid are asserted together. Each channel drops its valid after its own handshake, tracked by flags aw_done and w_done; handshakes may occur in either order or in the same cycle. When both are done -> B.
- B: bready=1. On bvalid, set err = (bresp!=0) -> DONE.
- DONE: out_valid=1 with all fields stable until out_ready, then -> IDLE. If in_valid is high in that same cycle, the new instruction is accepted and the FSM goes directly to its first state.
- Store formatting:
  - sb: wdata={4{rs2[7:0]}}, wstrb=0001<<a[1:0]
  - sh: wdata={2{rs2[15:0]}}, wstrb=0011<<{a[1],0}
  - sw: wdata=rs2, wstrb=1111
- Load extraction: shift rdata right by a[1:0]*8. b and h sign-extend; bu and hu zero-extend; w is passed as is.
- Misaligned accesses: a[0] is ignored for h, a[1:0] for w when forming strobe and extraction. The bus address is never modified.
- An error response forces Mem_rdata_o=0; the instruction still completes and mem_err_o travels with it.
- AXI valids never deassert before their handshake completes, even if out_ready or in_valid toggle.

Decomposition:
- Package ysyx_24100006_memu_pkg:
  - FSM state enum
  - Mem_Type codes
  - AXI resp codes (OKAY=00)
- Sub-module ysyx_24100006_mem_align: combinational store wdata/wstrb generation and load extract/extend, instantiated once.

Test Plan:
- Non-memory instruction (pc 0x80000000, alu_result 0x1234), out_ready=1 -> out_valid exactly 1 cycle after accept, no AXI activity, Mem_rdata_o=0.
- lb at 0x80001003, rdata=0x80FF_0000 -> Mem_rdata_o=0xFFFFFF80; lbu same -> 0x00000080; lhu at 0x80001002, rdata=0xBEEF1234 -> 0x0000BEEF.
- sh at 0x80002002, rs2=0x00005A5A -> awaddr=0x80002002, wdata=0x5A5A5A5A, wstrb=1100. awready comes 3 cycles before wready -> single bready handshake, then DONE.
- sw with awready/wready in the same cycle and bvalid delayed 5 cycles -> out_valid only after the B handshake; no duplicate AW or W beat.
- Load with rresp=10 -> mem_err_o=1 and Mem_rdata_o=0. out_ready held low 4 cycles -> outputs stable and in_ready=0 throughout.
- Reset asserted while in R with rvalid pending -> next cycle state IDLE, in_ready=1, out_valid=0, rready=0. The next lw completes normally.
